// File: rtl/fpga_operand_loader_if.sv
// ============================================================================
// Module      : fpga_operand_loader_if
// Description : Front-panel switch/key inputs and ALU operand/opcode outputs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fpga_operand_loader_if;
  logic [17:0] sw;
  logic [3:0]  key;
  logic [31:0] port_a;
  logic [31:0] port_b;
  logic [3:0]  opcode;
  logic        op_valid;
  logic [1:0]  entry_state;

  modport master (
    input  sw, key,
    output port_a, port_b, opcode, op_valid, entry_state
  );

  modport slave (
    output sw, key,
    input  port_a, port_b, opcode, op_valid, entry_state
  );
endinterface

`default_nettype wire

// File: rtl/fpga_operand_loader.sv
// ============================================================================
// Module      : fpga_operand_loader
// Description : Debounces front-panel keys and steps an A -> B -> opcode ->
//               result entry FSM that drives ALU operands from the switches.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fpga_operand_loader #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int CNT_W           = 18
) (
  input  logic                   clk,
  input  logic                   rst_n,
  fpga_operand_loader_if.master  bus
);

  localparam logic [CNT_W-1:0] c_cnt_max = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_LOAD_A  = 2'd0,
    S_LOAD_B  = 2'd1,
    S_LOAD_OP = 2'd2,
    S_RESULT  = 2'd3
  } state_t;

  logic [3:0] w_press;
  logic [1:0] r_settle;

  // Keys may only produce events once the synchronisers hold real samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_settle <= 2'b00;
    else        r_settle <= {r_settle[0], 1'b1};
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_key
    logic             r_sync1;
    logic             r_sync2;
    logic             r_db;
    logic             r_db_q;
    logic             r_armed;
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_sync1 <= 1'b1;
        r_sync2 <= 1'b1;
        r_db    <= 1'b1;
        r_db_q  <= 1'b1;
        r_armed <= 1'b0;
        r_cnt   <= '0;
      end else begin
        r_sync1 <= bus.key[gi];
        r_sync2 <= r_sync1;
        r_db_q  <= r_db;
        if (r_sync2 == r_db) begin
          r_cnt <= '0;
        end else if (r_cnt == c_cnt_max) begin
          r_db  <= r_sync2;
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
        // A key held through reset release must be seen released before it counts.
        if (r_settle[1] && r_db && r_sync2) r_armed <= 1'b1;
      end
    end

    assign w_press[gi] = r_armed & r_db_q & ~r_db;
  end

  logic w_unused_key2;
  assign w_unused_key2 = w_press[2];

  logic w_load;
  logic w_clr;
  logic w_back;
  assign w_load = w_press[0];
  assign w_clr  = w_press[1];
  assign w_back = w_press[3];

  logic [31:0] w_sw_ext;
  assign w_sw_ext = {{16{bus.sw[16]}}, bus.sw[15:0]};

  state_t      r_state;
  logic [31:0] r_port_a;
  logic [31:0] r_port_b;
  logic [3:0]  r_opcode;
  logic        r_op_valid;
  logic        r_hi_a;
  logic        r_hi_b;

  state_t      w_state_nxt;
  logic [31:0] w_port_a_nxt;
  logic [31:0] w_port_b_nxt;
  logic [3:0]  w_opcode_nxt;
  logic        w_op_valid_nxt;
  logic        w_hi_a_nxt;
  logic        w_hi_b_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_LOAD_A;
      r_port_a   <= '0;
      r_port_b   <= '0;
      r_opcode   <= '0;
      r_op_valid <= 1'b0;
      r_hi_a     <= 1'b0;
      r_hi_b     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_port_a   <= w_port_a_nxt;
      r_port_b   <= w_port_b_nxt;
      r_opcode   <= w_opcode_nxt;
      r_op_valid <= w_op_valid_nxt;
      r_hi_a     <= w_hi_a_nxt;
      r_hi_b     <= w_hi_b_nxt;
    end
  end

  // Clear beats back beats load; the losing events of that cycle are dropped.
  always_comb begin
    w_state_nxt    = r_state;
    w_port_a_nxt   = r_port_a;
    w_port_b_nxt   = r_port_b;
    w_opcode_nxt   = r_opcode;
    w_op_valid_nxt = r_op_valid;
    w_hi_a_nxt     = r_hi_a;
    w_hi_b_nxt     = r_hi_b;

    if (w_clr) begin
      w_state_nxt    = S_LOAD_A;
      w_port_a_nxt   = '0;
      w_port_b_nxt   = '0;
      w_opcode_nxt   = '0;
      w_op_valid_nxt = 1'b0;
      w_hi_a_nxt     = 1'b0;
      w_hi_b_nxt     = 1'b0;
    end else if (w_back) begin
      case (r_state)
        S_LOAD_B: begin
          w_state_nxt = S_LOAD_A;
          w_hi_a_nxt  = 1'b0;
        end
        S_LOAD_OP: begin
          w_state_nxt = S_LOAD_B;
          w_hi_b_nxt  = 1'b0;
        end
        S_RESULT: begin
          w_state_nxt    = S_LOAD_OP;
          w_op_valid_nxt = 1'b0;
        end
        default: ;
      endcase
    end else if (w_load) begin
      case (r_state)
        S_LOAD_A: begin
          if (bus.sw[17]) begin
            w_port_a_nxt[31:16] = bus.sw[15:0];
            w_hi_a_nxt          = 1'b1;
          end else if (r_hi_a) begin
            w_port_a_nxt[15:0] = bus.sw[15:0];
            w_hi_a_nxt         = 1'b0;
            w_state_nxt        = S_LOAD_B;
          end else begin
            w_port_a_nxt = w_sw_ext;
            w_state_nxt  = S_LOAD_B;
          end
        end
        S_LOAD_B: begin
          if (bus.sw[17]) begin
            w_port_b_nxt[31:16] = bus.sw[15:0];
            w_hi_b_nxt          = 1'b1;
          end else if (r_hi_b) begin
            w_port_b_nxt[15:0] = bus.sw[15:0];
            w_hi_b_nxt         = 1'b0;
            w_state_nxt        = S_LOAD_OP;
          end else begin
            w_port_b_nxt = w_sw_ext;
            w_state_nxt  = S_LOAD_OP;
          end
        end
        S_LOAD_OP: begin
          w_opcode_nxt   = bus.sw[3:0];
          w_op_valid_nxt = 1'b1;
          w_state_nxt    = S_RESULT;
        end
        default: begin
          w_op_valid_nxt = 1'b0;
          w_state_nxt    = S_LOAD_A;
        end
      endcase
    end
  end

  assign bus.port_a      = r_port_a;
  assign bus.port_b      = r_port_b;
  assign bus.opcode      = r_opcode;
  assign bus.op_valid    = r_op_valid;
  assign bus.entry_state = r_state;

endmodule

`default_nettype wire

// File: tb/tb_fpga_operand_loader.sv
// ============================================================================
// Module      : tb_fpga_operand_loader
// Description : Self-checking bench for fpga_operand_loader with a reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fpga_operand_loader;

  localparam int D = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fpga_operand_loader_if bus_if ();

  fpga_operand_loader #(
    .DEBOUNCE_CYCLES (D),
    .CNT_W           (3)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int n_changes;
  logic [1:0] prev_state;

  logic [31:0] m_a, m_b;
  logic [3:0]  m_op;
  logic        m_valid;
  int          m_state;
  bit          m_hi [2];

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h", tag, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (bus_if.entry_state !== prev_state) n_changes++;
      prev_state = bus_if.entry_state;
    end
  endtask

  task automatic check_all(input string tag);
    check_val({tag, ".portA"},  bus_if.port_a,             m_a);
    check_val({tag, ".portB"},  bus_if.port_b,             m_b);
    check_val({tag, ".opcode"}, 32'(bus_if.opcode),        32'(m_op));
    check_val({tag, ".valid"},  32'(bus_if.op_valid),      32'(m_valid));
    check_val({tag, ".state"},  32'(bus_if.entry_state),   32'(m_state));
  endtask

  task automatic model_reset();
    m_a = 0; m_b = 0; m_op = 0; m_valid = 0; m_state = 0;
    m_hi[0] = 0; m_hi[1] = 0;
  endtask

  // Operand rules expressed directly as arithmetic on the 32-bit value.
  function automatic logic [31:0] apply_operand(input logic [31:0] cur, input logic [17:0] sw,
                                                inout bit hi, inout int state);
    logic [31:0] lo16;
    lo16 = 32'(sw[15:0]);
    if (sw[17]) begin
      hi = 1;
      return (lo16 << 16) + (cur % 32'h10000);
    end
    state = state + 1;
    if (hi) begin
      hi = 0;
      return (cur / 32'h10000) * 32'h10000 + lo16;
    end
    return sw[16] ? 32'hFFFF0000 + lo16 : lo16;
  endfunction

  task automatic model_event(input bit ld, input bit bk, input bit cl, input logic [17:0] sw);
    if (cl) begin
      model_reset();
    end else if (bk) begin
      if (m_state == 1)      begin m_state = 0; m_hi[0] = 0; end
      else if (m_state == 2) begin m_state = 1; m_hi[1] = 0; end
      else if (m_state == 3) begin m_state = 2; m_valid = 0; end
    end else if (ld) begin
      if (m_state == 0)      m_a = apply_operand(m_a, sw, m_hi[0], m_state);
      else if (m_state == 1) m_b = apply_operand(m_b, sw, m_hi[1], m_state);
      else if (m_state == 2) begin m_op = sw[3:0]; m_valid = 1; m_state = 3; end
      else                   begin m_valid = 0; m_state = 0; end
    end
  endtask

  // Press keys in mask (active-low), optionally with bounce, then release.
  task automatic press(input logic [3:0] mask, input logic [17:0] sw, input bit bounce,
                       output int bounce_changes);
    bus_if.sw = sw;
    n_changes = 0;
    if (bounce) begin
      for (int i = 0; i < 5; i++) begin
        bus_if.key = ~mask; tick(2);
        bus_if.key = 4'hF;  tick(2);
      end
    end
    bounce_changes = n_changes;
    bus_if.key = ~mask; tick(D + 6);
    bus_if.key = 4'hF;  tick(D + 6);
    model_event(mask[0], mask[3], mask[1], sw);
  endtask

  int bc;
  int r;
  logic [3:0]  rmask;
  logic [17:0] rsw;

  initial begin
    bus_if.sw  = '0;
    bus_if.key = 4'hF;
    prev_state = 2'd0;
    model_reset();
    tick(3);
    rst_n = 1'b1;
    tick(4);
    check_all("reset");

    // Latency: event lands exactly D+3 edges after the key edge.
    bus_if.sw  = 18'h00007;
    bus_if.key = 4'hE;
    tick(D + 2);
    check_val("lat.before", 32'(bus_if.entry_state), 32'd0);
    tick(1);
    check_val("lat.after", 32'(bus_if.entry_state), 32'd1);
    bus_if.key = 4'hF;
    tick(D + 6);
    model_event(1, 0, 0, 18'h00007);
    check_all("lat");

    rst_n = 1'b0; tick(2); rst_n = 1'b1; tick(4);
    model_reset();
    check_all("reset2");

    // Bounce plus full entry
    press(4'b0001, 18'h10005, 1, bc);
    check_val("bounce.noevent", 32'(bc), 32'd0);
    check_val("bounce.one", 32'(n_changes), 32'd1);
    check_val("entry.a", bus_if.port_a, 32'hFFFF0005);
    check_all("entryA");
    press(4'b0001, 18'h00003, 0, bc);
    check_val("entry.b", bus_if.port_b, 32'h00000003);
    check_all("entryB");
    press(4'b0001, 18'h00002, 0, bc);
    check_val("entry.op", 32'(bus_if.opcode), 32'd2);
    check_val("entry.valid", 32'(bus_if.op_valid), 32'd1);
    check_val("entry.state", 32'(bus_if.entry_state), 32'd3);
    check_all("entryOP");

    // Back from RESULT
    press(4'b1000, 18'h3FFFF, 0, bc);
    check_val("back.valid", 32'(bus_if.op_valid), 32'd0);
    check_val("back.state", 32'(bus_if.entry_state), 32'd2);
    check_all("back");

    // Priority: clear wins over back and load
    press(4'b1011, 18'h0000F, 0, bc);
    check_val("prio.a", bus_if.port_a, 32'h0);
    check_val("prio.state", 32'(bus_if.entry_state), 32'd0);
    check_all("prio");
    press(4'b1000, 18'h00000, 0, bc);
    check_all("prio.backA");

    // 32-bit operand A
    press(4'b0001, 18'h2ABCD, 0, bc);
    check_val("a32.stay", 32'(bus_if.entry_state), 32'd0);
    press(4'b0001, 18'h01234, 0, bc);
    check_val("a32.a", bus_if.port_a, 32'hABCD1234);
    check_val("a32.state", 32'(bus_if.entry_state), 32'd1);
    check_all("a32");

    // Randomised sequences
    for (int it = 0; it < 40; it++) begin
      r   = $urandom_range(0, 19);
      rsw = 18'($urandom_range(0, 18'h3FFFF));
      if (r < 14)      rmask = 4'b0001;
      else if (r < 17) rmask = 4'b1000;
      else if (r < 19) rmask = 4'b0010;
      else             rmask = (4'($urandom) & 4'b1011) | 4'b0001;
      press(rmask, rsw, 1'($urandom), bc);
      check_all($sformatf("rnd%0d", it));
    end

    // Reset mid-debounce and mid-entry with the key held through release
    bus_if.sw  = 18'h00009;
    bus_if.key = 4'hE;
    tick(3);
    rst_n = 1'b0;
    tick(2);
    model_reset();
    check_all("rst.during");
    rst_n = 1'b1;
    tick(20);
    check_all("rst.held");
    bus_if.key = 4'hF;
    tick(D + 6);
    check_all("rst.released");
    press(4'b0001, 18'h00009, 0, bc);
    check_all("rst.repress");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
